// File: rtl/ant_pkg.sv
// Shared constants and types for the ANT+ serial transmit path.
package ant_pkg;

   localparam logic [7:0] ANT_SYNC = 8'hA4;

   localparam int unsigned ANT_MAX_PAYLOAD = 9;

   // Host-to-ANT and ANT-to-host message IDs used by this system.
   localparam logic [7:0] ANT_MSG_CHANNEL_EVENT   = 8'h40;
   localparam logic [7:0] ANT_MSG_ASSIGN_CHANNEL  = 8'h42;
   localparam logic [7:0] ANT_MSG_CHANNEL_PERIOD  = 8'h43;
   localparam logic [7:0] ANT_MSG_SEARCH_TIMEOUT  = 8'h44;
   localparam logic [7:0] ANT_MSG_RF_FREQ         = 8'h45;
   localparam logic [7:0] ANT_MSG_NETWORK_KEY     = 8'h46;
   localparam logic [7:0] ANT_MSG_RESET_SYSTEM    = 8'h4A;
   localparam logic [7:0] ANT_MSG_OPEN_CHANNEL    = 8'h4B;
   localparam logic [7:0] ANT_MSG_BROADCAST_DATA  = 8'h4E;
   localparam logic [7:0] ANT_MSG_CHANNEL_ID      = 8'h51;
   localparam logic [7:0] ANT_MSG_CAPABILITIES    = 8'h54;

   typedef enum logic [2:0] {
      StIdle,
      StLatch,
      StCtsWait,
      StStart,
      StWaitBusy,
      StWaitDone,
      StAck
   } ant_tx_state_t;

endpackage

// File: rtl/ant_frame_mux.sv
// Combinational byte selector for an ANT serial frame:
// SYNC, LEN, MSG_ID, payload bytes, CHECKSUM.
module ant_frame_mux
   import ant_pkg::*;
#(
   parameter int unsigned MAX_PAYLOAD = ANT_MAX_PAYLOAD
) (
   input  logic [3:0]               idx_i,
   input  logic [3:0]               last_idx_i,
   input  logic [3:0]               len_i,
   input  logic [7:0]               id_i,
   input  logic [8*MAX_PAYLOAD-1:0] data_i,
   input  logic [7:0]               csum_i,
   output logic [7:0]               byte_o
);

   // Checksum slot is tested first: for a zero-length frame it sits at index 3.
   always_comb begin
      byte_o = 8'h00;
      if (idx_i == last_idx_i) begin
         byte_o = csum_i;
      end else if (idx_i == 4'd0) begin
         byte_o = ANT_SYNC;
      end else if (idx_i == 4'd1) begin
         byte_o = {4'h0, len_i};
      end else if (idx_i == 4'd2) begin
         byte_o = id_i;
      end else begin
         for (int unsigned k = 0; k < MAX_PAYLOAD; k++) begin
            if (idx_i == 4'(k + 3)) byte_o = data_i[8*k +: 8];
         end
      end
   end

endmodule

// File: rtl/ant_msg_tx_arbiter.sv
// Two-port arbiter and ANT message framer feeding a byte-wide UART.
// Port A (configuration) has strict priority over port B (host).
module ant_msg_tx_arbiter
   import ant_pkg::*;
#(
   parameter int unsigned MAX_PAYLOAD  = ANT_MAX_PAYLOAD,
   parameter int unsigned BUSY_TIMEOUT = 16
) (
   input  logic                     c50m,
   input  logic                     reset,
   input  logic                     a_req,
   input  logic [7:0]               a_id,
   input  logic [3:0]               a_len,
   input  logic [8*MAX_PAYLOAD-1:0] a_data,
   output logic                     a_ack,
   input  logic                     b_req,
   input  logic [7:0]               b_id,
   input  logic [3:0]               b_len,
   input  logic [8*MAX_PAYLOAD-1:0] b_data,
   output logic                     b_ack,
   output logic                     err,
   output logic                     tx_start,
   output logic [7:0]               tx_byte,
   input  logic                     tx_busy,
   input  logic                     ant_cts,
   output logic                     busy
);

   localparam int unsigned DataW = 8 * MAX_PAYLOAD;
   localparam int unsigned CntW  = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [3:0]      MaxLen  = 4'(MAX_PAYLOAD);
   localparam logic [CntW-1:0] CntLast = CntW'(BUSY_TIMEOUT - 1);

   ant_tx_state_t    state_q, state_d;
   logic             grant_b_q, grant_b_d;
   logic             err_q, err_d;
   logic [7:0]       id_q, id_d;
   logic [3:0]       len_q, len_d;
   logic [DataW-1:0] data_q, data_d;
   logic [3:0]       idx_q, idx_d;
   logic [7:0]       csum_q, csum_d;
   logic [7:0]       tx_byte_q, tx_byte_d;
   logic [CntW-1:0]  cnt_q, cnt_d;

   logic [7:0]       sel_id;
   logic [3:0]       sel_len;
   logic [DataW-1:0] sel_data;
   logic [3:0]       last_idx;
   logic [7:0]       frame_byte;

   assign sel_id   = grant_b_q ? b_id   : a_id;
   assign sel_len  = grant_b_q ? b_len  : a_len;
   assign sel_data = grant_b_q ? b_data : a_data;
   // Frame length is len + 4, so the checksum sits at len + 3.
   assign last_idx = len_q + 4'd3;

   ant_frame_mux #(
      .MAX_PAYLOAD(MAX_PAYLOAD)
   ) u_frame_mux (
      .idx_i     (idx_q),
      .last_idx_i(last_idx),
      .len_i     (len_q),
      .id_i      (id_q),
      .data_i    (data_q),
      .csum_i    (csum_q),
      .byte_o    (frame_byte)
   );

   // State and datapath registers; reset abandons any frame in flight.
   always_ff @(posedge c50m) begin
      if (reset) begin
         state_q   <= StIdle;
         grant_b_q <= 1'b0;
         err_q     <= 1'b0;
         id_q      <= 8'h00;
         len_q     <= 4'h0;
         data_q    <= '0;
         idx_q     <= 4'h0;
         csum_q    <= 8'h00;
         tx_byte_q <= 8'h00;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         grant_b_q <= grant_b_d;
         err_q     <= err_d;
         id_q      <= id_d;
         len_q     <= len_d;
         data_q    <= data_d;
         idx_q     <= idx_d;
         csum_q    <= csum_d;
         tx_byte_q <= tx_byte_d;
         cnt_q     <= cnt_d;
      end
   end

   // Next-state logic: arbitrate, latch, then walk the frame one byte at a time.
   always_comb begin
      state_d   = state_q;
      grant_b_d = grant_b_q;
      err_d     = err_q;
      id_d      = id_q;
      len_d     = len_q;
      data_d    = data_q;
      idx_d     = idx_q;
      csum_d    = csum_q;
      tx_byte_d = tx_byte_q;
      cnt_d     = cnt_q;

      case (state_q)
         StIdle: begin
            err_d = 1'b0;
            if (a_req) begin
               grant_b_d = 1'b0;
               state_d   = StLatch;
            end else if (b_req) begin
               grant_b_d = 1'b1;
               state_d   = StLatch;
            end
         end
         StLatch: begin
            id_d   = sel_id;
            len_d  = sel_len;
            data_d = sel_data;
            idx_d  = 4'h0;
            csum_d = 8'h00;
            if (sel_len > MaxLen) begin
               err_d   = 1'b1;
               state_d = StAck;
            end else begin
               err_d   = 1'b0;
               state_d = StCtsWait;
            end
         end
         StCtsWait: begin
            tx_byte_d = frame_byte;
            if (!ant_cts && !tx_busy) state_d = StStart;
         end
         StStart: begin
            if (idx_q != last_idx) csum_d = csum_q ^ tx_byte_q;
            cnt_d   = '0;
            state_d = StWaitBusy;
         end
         StWaitBusy: begin
            if (tx_busy) begin
               state_d = StWaitDone;
            end else if (cnt_q == CntLast) begin
               err_d   = 1'b1;
               state_d = StAck;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StWaitDone: begin
            if (!tx_busy) begin
               if (idx_q == last_idx) begin
                  err_d   = 1'b0;
                  state_d = StAck;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = StCtsWait;
               end
            end
         end
         StAck: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign tx_start = (state_q == StStart);
   assign tx_byte  = tx_byte_q;
   assign busy     = (state_q != StIdle);
   assign a_ack    = (state_q == StAck) && !grant_b_q;
   assign b_ack    = (state_q == StAck) && grant_b_q;
   assign err      = (state_q == StAck) && err_q;

endmodule

// File: tb/tb_ant_msg_tx_arbiter.sv
// Self-checking bench for ant_msg_tx_arbiter: directed table, corner
// sequences and randomized traffic checked against a frame model.
module tb_ant_msg_tx_arbiter;

   localparam int unsigned MaxPay  = 9;
   localparam int unsigned Timeout = 16;

   logic             c50m = 1'b0;
   logic             reset;
   logic             a_req, b_req;
   logic [7:0]       a_id, b_id;
   logic [3:0]       a_len, b_len;
   logic [8*MaxPay-1:0] a_data, b_data;
   logic             a_ack, b_ack, err, tx_start, busy;
   logic [7:0]       tx_byte;
   logic             tx_busy = 1'b0;
   logic             ant_cts;

   ant_msg_tx_arbiter #(
      .MAX_PAYLOAD (MaxPay),
      .BUSY_TIMEOUT(Timeout)
   ) dut (
      .c50m    (c50m),
      .reset   (reset),
      .a_req   (a_req),
      .a_id    (a_id),
      .a_len   (a_len),
      .a_data  (a_data),
      .a_ack   (a_ack),
      .b_req   (b_req),
      .b_id    (b_id),
      .b_len   (b_len),
      .b_data  (b_data),
      .b_ack   (b_ack),
      .err     (err),
      .tx_start(tx_start),
      .tx_byte (tx_byte),
      .tx_busy (tx_busy),
      .ant_cts (ant_cts),
      .busy    (busy)
   );

   always #10 c50m = ~c50m;

   int checks = 0;
   int errors = 0;

   // UART model: records every started byte, busy rises the next cycle.
   logic [7:0] got_q[$];
   int  uart_hold = 1;
   bit  uart_dead = 1'b0;
   int  uart_cnt  = 0;

   always @(posedge c50m) begin
      if (tx_start) got_q.push_back(tx_byte);
      if (uart_cnt != 0) begin
         uart_cnt <= uart_cnt - 1;
         if (uart_cnt == 1) tx_busy <= 1'b0;
      end else if (tx_start && !uart_dead) begin
         tx_busy  <= 1'b1;
         uart_cnt <= uart_hold;
      end
   end

   int stray_err = 0;
   int collide   = 0;
   int ack_count = 0;
   always @(negedge c50m) begin
      if (err && !a_ack && !b_ack) stray_err++;
      if (a_ack && b_ack) collide++;
      if (a_ack || b_ack) ack_count++;
   end

   initial begin
      #1_200_000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   // Reference frame model
   logic [7:0] exp_q[$];
   bit         exp_err;

   function automatic void build_expected(input logic [7:0] id, input int len,
                                          input logic [8*MaxPay-1:0] data, input bit append);
      logic [7:0] x;
      logic [7:0] bytes[$];
      if (!append) exp_q.delete();
      exp_err = (len > int'(MaxPay));
      if (exp_err) return;
      bytes.push_back(8'hA4);
      bytes.push_back(8'(len));
      bytes.push_back(id);
      for (int i = 0; i < len; i++) bytes.push_back(data[8*i +: 8]);
      x = 8'h00;
      foreach (bytes[i]) x = x ^ bytes[i];
      bytes.push_back(x);
      foreach (bytes[i]) exp_q.push_back(bytes[i]);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic compare_frame(input string name, input int base);
      int n;
      n = got_q.size() - base;
      check({name, "_nbytes"}, n, exp_q.size());
      for (int i = 0; i < n && i < exp_q.size(); i++)
         check($sformatf("%s_byte%0d", name, i), int'(got_q[base+i]), int'(exp_q[i]));
   endtask

   bit cts_rand = 1'b0;

   task automatic wait_ack(input int limit, output bit ga, output bit gb, output bit ge,
                           output int cyc, output bit to);
      ga = 0; gb = 0; ge = 0; cyc = 0; to = 0;
      forever begin
         @(negedge c50m);
         cyc++;
         if (a_ack || b_ack) begin
            ga = a_ack; gb = b_ack; ge = err;
            break;
         end
         if (cyc >= limit) begin
            to = 1;
            break;
         end
         if (cts_rand) ant_cts = ($urandom_range(0, 3) == 0);
      end
      if (cts_rand) ant_cts = 1'b0;
   endtask

   task automatic drive_req(input bit port_b, input logic [7:0] id, input int len,
                            input logic [8*MaxPay-1:0] data);
      if (port_b) begin
         b_id = id; b_len = 4'(len); b_data = data; b_req = 1'b1;
      end else begin
         a_id = id; a_len = 4'(len); a_data = data; a_req = 1'b1;
      end
   endtask

   task automatic run_txn(input string name, input bit port_b, input logic [7:0] id,
                          input int len, input logic [8*MaxPay-1:0] data, input int hold);
      bit ga, gb, ge, to;
      int cyc, base;
      build_expected(id, len, data, 1'b0);
      uart_hold = hold;
      @(negedge c50m);
      base = got_q.size();
      drive_req(port_b, id, len, data);
      wait_ack(5000, ga, gb, ge, cyc, to);
      a_req = 1'b0;
      b_req = 1'b0;
      check({name, "_timeout"}, int'(to), 0);
      check({name, "_ack_port"}, int'({ga, gb}), port_b ? 1 : 2);
      check({name, "_err"}, int'(ge), int'(exp_err));
      compare_frame(name, base);
   endtask

   typedef struct {
      bit          port_b;
      logic [7:0]  id;
      int          len;
      logic [8*MaxPay-1:0] data;
      int          hold;
      bit          exp_err;
      logic [7:0]  exp_csum;
   } vec_t;

   vec_t vecs[6];

   initial begin
      bit ga, gb, ge, to;
      int cyc, base, c0, acks0, n;
      logic [95:0] r96;

      vecs[0] = '{0, 8'h4A, 1,  72'h00,    1, 0, 8'hEF};
      vecs[1] = '{1, 8'h4E, 0,  72'h00,    2, 0, 8'hEA};
      vecs[2] = '{0, 8'h4B, 1,  72'h00,    3, 0, 8'hEE};
      vecs[3] = '{1, 8'h43, 2,  72'h2000,  1, 0, 8'hC5};
      vecs[4] = '{0, 8'h46, 10, 72'h1234,  1, 1, 8'h00};
      vecs[5] = '{1, 8'h4E, 12, 72'h55,    1, 1, 8'h00};

      reset = 1'b1; a_req = 0; b_req = 0; ant_cts = 0;
      a_id = 0; b_id = 0; a_len = 0; b_len = 0; a_data = '0; b_data = '0;
      repeat (3) @(negedge c50m);
      check("rst_a_ack", int'(a_ack), 0);
      check("rst_b_ack", int'(b_ack), 0);
      check("rst_err", int'(err), 0);
      check("rst_tx_start", int'(tx_start), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_tx_byte", int'(tx_byte), 0);
      reset = 1'b0;

      // Directed table
      for (int i = 0; i < 6; i++) begin
         run_txn($sformatf("vec%0d", i), vecs[i].port_b, vecs[i].id, vecs[i].len,
                 vecs[i].data, vecs[i].hold);
         if (!vecs[i].exp_err && got_q.size() > 0)
            check($sformatf("vec%0d_csum", i), int'(got_q[got_q.size()-1]),
                  int'(vecs[i].exp_csum));
         @(negedge c50m);
         check($sformatf("vec%0d_idle", i), int'(busy), 0);
      end

      // Simultaneous requests: A first, then B
      build_expected(8'h4B, 1, 72'h00, 1'b0);
      build_expected(8'h4E, 0, 72'h00, 1'b1);
      uart_hold = 1;
      @(negedge c50m);
      base = got_q.size();
      drive_req(1'b0, 8'h4B, 1, 72'h00);
      drive_req(1'b1, 8'h4E, 0, 72'h00);
      wait_ack(2000, ga, gb, ge, cyc, to);
      a_req = 1'b0;
      check("both_first_ack", int'({ga, gb, to}), 3'b100);
      check("both_first_nbytes", got_q.size() - base, 5);
      wait_ack(2000, ga, gb, ge, cyc, to);
      b_req = 1'b0;
      check("both_second_ack", int'({ga, gb, ge, to}), 4'b0100);
      compare_frame("both", base);

      // CTS held high mid-frame on a network-key message
      build_expected(8'h46, 9, 72'hB9A5_21FB_BDD8_00C1_00, 1'b0);
      @(negedge c50m);
      base = got_q.size();
      drive_req(1'b0, 8'h46, 9, 72'hB9A5_21FB_BDD8_00C1_00);
      cyc = 0;
      while (got_q.size() - base < 2 && cyc < 500) begin
         @(negedge c50m);
         cyc++;
      end
      check("cts_reach_byte2", int'(cyc < 500), 1);
      ant_cts = 1'b1;
      c0 = got_q.size();
      repeat (200) @(negedge c50m);
      check("cts_hold_no_start", got_q.size(), c0);
      check("cts_hold_busy", int'(busy), 1);
      ant_cts = 1'b0;
      wait_ack(2000, ga, gb, ge, cyc, to);
      a_req = 1'b0;
      check("cts_ack", int'({ga, gb, ge, to}), 4'b1000);
      check("cts_total", got_q.size() - base, 13);
      compare_frame("cts", base);

      // Oversize length: rejected two cycles after the request is seen
      @(negedge c50m);
      base = got_q.size();
      drive_req(1'b1, 8'h4E, 10, 72'h00);
      wait_ack(50, ga, gb, ge, cyc, to);
      b_req = 1'b0;
      check("badlen_ack", int'({ga, gb, ge, to}), 4'b0110);
      check("badlen_latency", cyc, 2);
      check("badlen_no_tx", got_q.size() - base, 0);

      // UART never goes busy
      uart_dead = 1'b1;
      @(negedge c50m);
      base = got_q.size();
      drive_req(1'b0, 8'h4A, 0, 72'h00);
      cyc = 0;
      while (!tx_start && cyc < 50) begin
         @(negedge c50m);
         cyc++;
      end
      check("tmo_start_seen", int'(tx_start), 1);
      wait_ack(100, ga, gb, ge, cyc, to);
      a_req = 1'b0;
      uart_dead = 1'b0;
      check("tmo_ack", int'({ga, gb, ge, to}), 4'b1010);
      check("tmo_latency", cyc, Timeout + 1);
      check("tmo_nbytes", got_q.size() - base, 1);
      @(negedge c50m);
      check("tmo_busy_drop", int'(busy), 0);
      run_txn("after_tmo", 1'b1, 8'h54, 0, 72'h00, 1);

      // Reset in the middle of the payload
      uart_hold = 2;
      @(negedge c50m);
      base = got_q.size();
      drive_req(1'b0, 8'h4E, 5, 72'h55_44_33_22_11);
      cyc = 0;
      while (got_q.size() - base < 4 && cyc < 500) begin
         @(negedge c50m);
         cyc++;
      end
      acks0 = ack_count;
      reset = 1'b1;
      a_req = 1'b0;
      @(negedge c50m);
      check("mrst_busy", int'(busy), 0);
      check("mrst_tx_start", int'(tx_start), 0);
      check("mrst_tx_byte", int'(tx_byte), 0);
      check("mrst_acks", int'({a_ack, b_ack, err}), 0);
      reset = 1'b0;
      repeat (5) @(negedge c50m);
      check("mrst_no_ack", ack_count, acks0);
      run_txn("after_rst", 1'b0, 8'h4B, 1, 72'h00, 1);

      // Randomized traffic with CTS noise
      cts_rand = 1'b1;
      for (int i = 0; i < 25; i++) begin
         r96 = {$urandom(), $urandom(), $urandom()};
         n = $urandom_range(0, 10);
         run_txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 8'($urandom()), n,
                 r96[71:0], $urandom_range(1, 3));
      end
      cts_rand = 1'b0;
      ant_cts = 1'b0;

      repeat (3) @(negedge c50m);
      check("err_only_with_ack", stray_err, 0);
      check("ack_collision", collide, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
